// File: rtl/icache_sa.sv
// icache_sa: parametrised N-way set-associative read-only instruction cache with
// true-LRU replacement, ready-based line fill, DMA bus deferral and statistics.
module icache_sa #(
  parameter int ADDR_W     = 16,
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 2,
  parameter int WAYS       = 2,
  parameter int CNT_W      = 17
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_m,
  input  logic [ADDR_W-1:0]            memory_address,
  output logic [WORD_W-1:0]            data,
  output logic                         hit,
  output logic                         miss,
  output logic                         mem_read_m,
  output logic [ADDR_W-1:0]            out_address,
  input  logic [WORD_W*LINE_WORDS-1:0] instruction,
  input  logic                         mem_ready,
  input  logic                         BG_input,
  input  logic                         invalidate,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count,
  output logic [CNT_W-1:0]             evict_count
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int SET_BITS = $clog2(SETS);
  localparam int SET_W    = (SETS > 1) ? SET_BITS : 1;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W    = ADDR_W - OFF_W - SET_BITS;
  localparam int LINE_W   = WORD_W * LINE_WORDS;
  localparam int LADDR_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_BG = 2'd1,
    REQ     = 2'd2
  } state_t;

  state_t               state_r;
  logic                 mem_read_r;
  logic [LADDR_W-1:0]   line_addr_r;
  logic                 inv_pend_r;

  logic                 valid_r [SETS][WAYS];
  logic [TAG_W-1:0]     tag_r   [SETS][WAYS];
  logic [LINE_W-1:0]    line_r  [SETS][WAYS];
  logic [WAY_W-1:0]     age_r   [SETS][WAYS];

  logic [CNT_W-1:0]     hit_cnt_r;
  logic [CNT_W-1:0]     miss_cnt_r;
  logic [CNT_W-1:0]     evict_cnt_r;

  logic [OFF_W-1:0]     lk_off_s;
  logic [SET_W-1:0]     lk_set_s;
  logic [SET_W-1:0]     fill_set_s;
  logic [TAG_W-1:0]     lk_tag_s;
  logic [TAG_W-1:0]     fill_tag_s;
  logic [WAYS-1:0]      hit_vec_s;
  logic [WAYS-1:0]      inval_vec_s;
  logic [WAYS-1:0]      old_vec_s;
  logic [WAY_W-1:0]     hit_way_s;
  logic [WAY_W-1:0]     victim_s;
  logic                 hit_any_s;
  logic                 evict_s;
  logic                 hit_s;
  logic                 miss_s;
  logic                 fill_s;
  logic                 install_s;
  logic                 upd_en_s;
  logic [SET_W-1:0]     upd_set_s;
  logic [WAY_W-1:0]     upd_way_s;
  logic [WAY_W-1:0]     upd_age_s;
  logic [LINE_W-1:0]    hit_line_s;

  assign lk_off_s   = memory_address[OFF_W-1:0];
  assign lk_tag_s   = memory_address[ADDR_W-1:OFF_W+SET_BITS];
  assign fill_tag_s = line_addr_r[LADDR_W-1:SET_BITS];

  generate
    if (SETS > 1) begin : g_idx
      assign lk_set_s   = memory_address[OFF_W +: SET_BITS];
      assign fill_set_s = line_addr_r[SET_BITS-1:0];
    end else begin : g_no_idx
      assign lk_set_s   = 1'b0;
      assign fill_set_s = 1'b0;
    end
  endgenerate

  // Per-way tag compare for the lookup set and victim candidates for the fill set
  always_comb begin
    hit_vec_s   = '0;
    inval_vec_s = '0;
    old_vec_s   = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w]   = valid_r[lk_set_s][w] && (tag_r[lk_set_s][w] == lk_tag_s);
      inval_vec_s[w] = !valid_r[fill_set_s][w];
      old_vec_s[w]   = (age_r[fill_set_s][w] == WAY_W'(WAYS - 1));
    end
  end

  // Priority encoders: the lowest invalid way beats the oldest way as victim
  always_comb begin
    hit_way_s = '0;
    victim_s  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way_s = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
      victim_s  = old_vec_s[w] ? WAY_W'(w) : victim_s;
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      victim_s = inval_vec_s[w] ? WAY_W'(w) : victim_s;
    end
  end

  assign hit_any_s  = |hit_vec_s;
  assign evict_s    = ~|inval_vec_s;
  assign hit_s      = read_m && (state_r == IDLE) && hit_any_s;
  assign miss_s     = read_m && !hit_s;
  assign fill_s     = (state_r == REQ) && mem_ready;
  // A fill overlapping an invalidate is consumed from the bus but never installed
  assign install_s  = fill_s && !invalidate && !inv_pend_r;
  assign upd_en_s   = hit_s || install_s;
  assign upd_set_s  = hit_s ? lk_set_s : fill_set_s;
  assign upd_way_s  = hit_s ? hit_way_s : victim_s;
  assign upd_age_s  = age_r[upd_set_s][upd_way_s];
  assign hit_line_s = line_r[lk_set_s][hit_way_s];

  assign data        = hit_s ? hit_line_s[lk_off_s*WORD_W +: WORD_W] : {WORD_W{1'b0}};
  assign hit         = hit_s;
  assign miss        = miss_s;
  assign mem_read_m  = mem_read_r;
  assign out_address = {line_addr_r, {OFF_W{1'b0}}};
  assign hit_count   = hit_cnt_r;
  assign miss_count  = miss_cnt_r;
  assign evict_count = evict_cnt_r;

  // Fetch FSM with registered memory request and latched line address
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      mem_read_r  <= 1'b0;
      line_addr_r <= '0;
      inv_pend_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            if (BG_input) begin
              state_r <= WAIT_BG;
            end else begin
              state_r     <= REQ;
              mem_read_r  <= 1'b1;
              line_addr_r <= memory_address[ADDR_W-1:OFF_W];
              inv_pend_r  <= 1'b0;
            end
          end
        end
        WAIT_BG: begin
          if (!read_m) begin
            state_r <= IDLE;
          end else if (!BG_input) begin
            state_r     <= REQ;
            mem_read_r  <= 1'b1;
            line_addr_r <= memory_address[ADDR_W-1:OFF_W];
            inv_pend_r  <= 1'b0;
          end
        end
        REQ: begin
          if (mem_ready) begin
            state_r    <= IDLE;
            mem_read_r <= 1'b0;
            inv_pend_r <= 1'b0;
          end else if (invalidate) begin
            inv_pend_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          mem_read_r <= 1'b0;
          inv_pend_r <= 1'b0;
        end
      endcase
    end
  end

  // Line storage, LRU ages and statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          tag_r[s][w]   <= '0;
          line_r[s][w]  <= '0;
          age_r[s][w]   <= WAY_W'(w);
        end
      end
      hit_cnt_r   <= '0;
      miss_cnt_r  <= '0;
      evict_cnt_r <= '0;
    end else begin
      if (hit_s) begin
        hit_cnt_r <= hit_cnt_r + CNT_W'(1);
      end
      if (install_s) begin
        valid_r[fill_set_s][victim_s] <= 1'b1;
        tag_r[fill_set_s][victim_s]   <= fill_tag_s;
        line_r[fill_set_s][victim_s]  <= instruction;
        miss_cnt_r <= miss_cnt_r + CNT_W'(1);
        if (evict_s) begin
          evict_cnt_r <= evict_cnt_r + CNT_W'(1);
        end
      end
      if (upd_en_s) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == upd_way_s) begin
            age_r[upd_set_s][w] <= '0;
          end else if (age_r[upd_set_s][w] < upd_age_s) begin
            age_r[upd_set_s][w] <= age_r[upd_set_s][w] + WAY_W'(1);
          end
        end
      end
      if (invalidate) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) begin
            valid_r[s][w] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: a default 2-set/2-way instance and a
// 1-set/4-way instance, both checked against a recency-list cache model.
module tb_icache_sa;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        read_m;
  logic [15:0] memory_address;
  logic [63:0] instruction;
  logic        mem_ready;
  logic        BG_input;
  logic        invalidate;

  logic [15:0] data_a, data_b, out_addr_a, out_addr_b;
  logic        hit_a, hit_b, miss_a, miss_b, mrd_a, mrd_b;
  logic [16:0] hc_a, hc_b, mc_a, mc_b, ec_a, ec_b;

  logic [15:0] data_o, out_addr_o;
  logic        hit_o, miss_o, mrd_o;
  logic [16:0] hc_o, mc_o, ec_o;

  int checks;
  int errors;

  typedef struct packed {
    logic [13:0] la;
    logic [63:0] d;
  } ent_t;

  // Model: per (dut, set) list of resident lines, most recently used first
  ent_t mq [4][$];
  int   m_hits [2];
  int   m_miss [2];
  int   m_evict[2];
  bit          ovr_en;
  logic [63:0] ovr_line;

  icache_sa u_dut_a (
    .clk(clk), .reset(reset), .read_m(read_m & ~sel), .memory_address(memory_address),
    .data(data_a), .hit(hit_a), .miss(miss_a), .mem_read_m(mrd_a), .out_address(out_addr_a),
    .instruction(instruction), .mem_ready(mem_ready & ~sel), .BG_input(BG_input),
    .invalidate(invalidate & ~sel), .hit_count(hc_a), .miss_count(mc_a), .evict_count(ec_a)
  );

  icache_sa #(.SETS(1), .WAYS(4)) u_dut_b (
    .clk(clk), .reset(reset), .read_m(read_m & sel), .memory_address(memory_address),
    .data(data_b), .hit(hit_b), .miss(miss_b), .mem_read_m(mrd_b), .out_address(out_addr_b),
    .instruction(instruction), .mem_ready(mem_ready & sel), .BG_input(BG_input),
    .invalidate(invalidate & sel), .hit_count(hc_b), .miss_count(mc_b), .evict_count(ec_b)
  );

  assign data_o     = sel ? data_b : data_a;
  assign out_addr_o = sel ? out_addr_b : out_addr_a;
  assign hit_o      = sel ? hit_b : hit_a;
  assign miss_o     = sel ? miss_b : miss_a;
  assign mrd_o      = sel ? mrd_b : mrd_a;
  assign hc_o       = sel ? hc_b : hc_a;
  assign mc_o       = sel ? mc_b : mc_a;
  assign ec_o       = sel ? ec_b : ec_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nsets(input int d);
    return (d != 0) ? 1 : 2;
  endfunction

  function automatic int nways(input int d);
    return (d != 0) ? 4 : 2;
  endfunction

  function automatic logic [63:0] gen_line(input logic [13:0] la);
    logic [15:0] x;
    x = {2'b00, la};
    return {x ^ 16'hA5A5, x * 16'd3 + 16'd7, ~x, x + 16'h1234};
  endfunction

  function automatic int find(input int k, input logic [13:0] la);
    for (int i = 0; i < mq[k].size(); i++) begin
      if (mq[k][i].la == la) return i;
    end
    return -1;
  endfunction

  task automatic model_clear(input int d);
    for (int s = 0; s < nsets(d); s++) mq[d*2+s].delete();
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      m_hits[d] = 0; m_miss[d] = 0; m_evict[d] = 0;
    end
  endtask

  task automatic model_install(input int d, input int k, input logic [13:0] la, input logic [63:0] ln);
    ent_t e;
    if (mq[k].size() == nways(d)) begin
      mq[k].delete(mq[k].size() - 1);
      m_evict[d]++;
    end
    e.la = la;
    e.d  = ln;
    mq[k].push_front(e);
    m_miss[d]++;
  endtask

  task automatic do_reset();
    reset = 1'b1; read_m = 1'b0; mem_ready = 1'b0; invalidate = 1'b0; BG_input = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_counters(input int d, input string tag);
    sel = (d != 0);
    #1;
    checks++;
    if (hc_o !== 17'(m_hits[d])) begin
      errors++; $display("FAIL %s hit_count: got %0d expected %0d", tag, hc_o, m_hits[d]);
    end
    checks++;
    if (mc_o !== 17'(m_miss[d])) begin
      errors++; $display("FAIL %s miss_count: got %0d expected %0d", tag, mc_o, m_miss[d]);
    end
    checks++;
    if (ec_o !== 17'(m_evict[d])) begin
      errors++; $display("FAIL %s evict_count: got %0d expected %0d", tag, ec_o, m_evict[d]);
    end
  endtask

  // One pipeline fetch held until hit; serves the line after lat cycles of request
  task automatic fetch(input int d, input logic [15:0] a, input int lat, input int bg, input bit inv);
    int          k, idx;
    logic [13:0] la;
    logic [63:0] ln;
    logic [15:0] exp_w;
    ent_t        e;
    bit          done;
    la = a[15:2];
    k  = d * 2 + (int'(la) % nsets(d));
    sel = (d != 0); memory_address = a; read_m = 1'b1; done = 1'b0;
    for (int att = 0; att < 3 && !done; att++) begin
      #1;
      idx = find(k, la);
      checks++;
      if (hit_o !== (idx >= 0)) begin
        errors++; $display("FAIL hit @%h: got %b expected %b", a, hit_o, idx >= 0);
      end
      checks++;
      if (miss_o !== (idx < 0)) begin
        errors++; $display("FAIL miss @%h: got %b expected %b", a, miss_o, idx < 0);
      end
      checks++;
      if (mrd_o !== 1'b0) begin
        errors++; $display("FAIL mem_read_m idle @%h: got %b expected 0", a, mrd_o);
      end
      if (idx >= 0) begin
        ln    = mq[k][idx].d;
        exp_w = ln[int'(a[1:0])*16 +: 16];
        checks++;
        if (data_o !== exp_w) begin
          errors++; $display("FAIL data @%h: got %h expected %h", a, data_o, exp_w);
        end
        e = mq[k][idx];
        mq[k].delete(idx);
        mq[k].push_front(e);
        m_hits[d]++;
        @(negedge clk);
        done = 1'b1;
      end else begin
        ln = ovr_en ? ovr_line : gen_line(la);
        BG_input = (bg > 0);
        for (int c = 1; c <= bg; c++) begin
          @(negedge clk);
          if (c == bg) BG_input = 1'b0;
          #1;
          checks++;
          if (mrd_o !== 1'b0 || miss_o !== 1'b1 || hit_o !== 1'b0) begin
            errors++; $display("FAIL wait_bg c%0d: got mrd=%b miss=%b hit=%b expected 0 1 0", c, mrd_o, miss_o, hit_o);
          end
        end
        for (int c = 1; c <= lat; c++) begin
          @(negedge clk);
          BG_input = 1'($urandom_range(0, 1));
          if (c == lat) begin
            mem_ready = 1'b1; instruction = ln; invalidate = inv && (att == 0);
          end
          #1;
          checks++;
          if (mrd_o !== 1'b1 || miss_o !== 1'b1 || hit_o !== 1'b0) begin
            errors++; $display("FAIL req c%0d: got mrd=%b miss=%b hit=%b expected 1 1 0", c, mrd_o, miss_o, hit_o);
          end
          checks++;
          if (out_addr_o !== {la, 2'b00}) begin
            errors++; $display("FAIL out_address c%0d: got %h expected %h", c, out_addr_o, {la, 2'b00});
          end
        end
        @(negedge clk);
        mem_ready = 1'b0; invalidate = 1'b0; BG_input = 1'b0; instruction = 64'h0;
        if (inv && att == 0) model_clear(d);
        else model_install(d, k, la, ln);
      end
    end
    read_m = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sel = (d != 0);
      #1;
      checks++;
      if (mrd_o !== 1'b0 || out_addr_o !== 16'h0000) begin
        errors++; $display("FAIL reset mem_if d%0d: got mrd=%b addr=%h expected 0 0000", d, mrd_o, out_addr_o);
      end
      checks++;
      if (hit_o !== 1'b0 || miss_o !== 1'b0 || data_o !== 16'h0000) begin
        errors++; $display("FAIL idle outputs d%0d: got hit=%b miss=%b data=%h expected 0 0 0000", d, hit_o, miss_o, data_o);
      end
      check_counters(d, "reset");
    end
    sel = 1'b0; memory_address = 16'h0000; read_m = 1'b1;
    #1;
    checks++;
    if (miss_o !== 1'b1 || hit_o !== 1'b0 || data_o !== 16'h0000) begin
      errors++; $display("FAIL cold lookup: got miss=%b hit=%b data=%h expected 1 0 0000", miss_o, hit_o, data_o);
    end
    read_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_fetch();
    ovr_en = 1'b1; ovr_line = 64'h4444_3333_2222_1111;
    fetch(0, 16'h0012, 3, 0, 1'b0);
    ovr_en = 1'b0;
    check_counters(0, "cold");
  endtask

  task automatic test_lru();
    do_reset();
    fetch(0, 16'h0000, 2, 0, 1'b0);
    fetch(0, 16'h0008, 2, 0, 1'b0);
    fetch(0, 16'h0000, 2, 0, 1'b0);
    fetch(0, 16'h0010, 2, 0, 1'b0);
    check_counters(0, "lru_evict");
    fetch(0, 16'h0001, 1, 0, 1'b0);
    fetch(0, 16'h0008, 1, 0, 1'b0);
    check_counters(0, "lru_refetch");
  endtask

  task automatic test_bg();
    fetch(0, 16'h0020, 2, 5, 1'b0);
    check_counters(0, "bg");
  endtask

  task automatic test_invalidate();
    fetch(0, 16'h0030, 2, 0, 1'b1);
    check_counters(0, "inv_fill");
    sel = 1'b0; invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    model_clear(0);
    fetch(0, 16'h0031, 3, 0, 1'b0);
    check_counters(0, "inv_idle");
  endtask

  task automatic test_reset_mid_req();
    fetch(0, 16'h0040, 2, 0, 1'b0);
    sel = 1'b0; memory_address = 16'h0050; read_m = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (mrd_o !== 1'b1) begin
      errors++; $display("FAIL pre-reset req: got mrd=%b expected 1", mrd_o);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; read_m = 1'b0; mem_ready = 1'b1; instruction = gen_line(14'h0014);
    model_reset();
    #1;
    checks++;
    if (mrd_o !== 1'b0) begin
      errors++; $display("FAIL post-reset mem_read_m: got %b expected 0", mrd_o);
    end
    check_counters(0, "mid_req_reset");
    @(negedge clk);
    mem_ready = 1'b0; instruction = 64'h0;
    fetch(0, 16'h0040, 2, 0, 1'b0);
    fetch(0, 16'h0050, 2, 0, 1'b0);
    check_counters(0, "after_reset");
  endtask

  task automatic test_4way();
    do_reset();
    for (int i = 0; i < 5; i++) fetch(1, 16'(i * 4), 2, 0, 1'b0);
    for (int i = 1; i < 5; i++) fetch(1, 16'(i * 4 + 1), 1, 0, 1'b0);
    fetch(1, 16'h0000, 2, 0, 1'b0);
    check_counters(1, "4way");
  endtask

  task automatic test_random();
    int d;
    for (int n = 0; n < 80; n++) begin
      d = int'($urandom_range(0, 1));
      fetch(d, 16'($urandom_range(0, 47)), int'($urandom_range(1, 4)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            ($urandom_range(0, 15) == 0));
    end
    check_counters(0, "rand_a");
    check_counters(1, "rand_b");
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; sel = 1'b0; read_m = 1'b0; memory_address = 16'h0000;
    instruction = 64'h0; mem_ready = 1'b0; BG_input = 1'b0; invalidate = 1'b0;
    ovr_en = 1'b0; ovr_line = 64'h0;
    model_reset();
    test_reset();
    test_cold_fetch();
    test_lru();
    test_bg();
    test_invalidate();
    test_reset_mid_req();
    test_4way();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised N-way set-associative, read-only instruction cache that sits between the pipeline's instruction-fetch stage and the shared memory bus. It generalises the fixed 2-set/2-way fetch cache to configurable sets, ways and line size, with true-LRU replacement, a ready-based memory handshake instead of a fixed-latency counter, and a global invalidate. It defers line fills while the DMA engine holds the bus grant. It also exports hit, miss and evict statistics.

## Interface
- ADDR_W, 16, byte-free word address width
- WORD_W, 16, instruction word width
- LINE_WORDS, 4, words per line (power of 2, ≥2)
- SETS, 2, number of sets (power of 2, ≥1)
- WAYS, 2, associativity (power of 2, 1..8)
- CNT_W, 17, statistics counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- read_m  in  1  fetch request, level, held by pipeline until hit
- memory_address  in  ADDR_W  fetch word address
- data  out  WORD_W  fetched word; valid when hit=1, else 0
- hit  out  1  fetch served this cycle
- miss  out  1  read_m=1 and not hit (pipeline stall)
- mem_read_m  out  1  line read request to memory
- out_address  out  ADDR_W  line-aligned address (low log2(LINE_WORDS) bits 0)
- instruction  in  WORD_W*LINE_WORDS  returned line, word 0 in LSBs
- mem_ready  in  1  line valid on instruction this cycle
- BG_input  in  1  bus granted to DMA; cache must not start a request
- invalidate  in  1  clear all valid bits
- hit_count, miss_count, evict_count  out  CNT_W each  statistics

## Operation
- Address split: offset = low log2(LINE_WORDS) bits, index = next log2(SETS) bits, tag = remainder.
- States: IDLE, WAIT_BG, REQ.
- IDLE: lookup is combinational. Hit = read_m & valid & tag match in any way. On a hit, data = selected word, and LRU updates at the edge.
- Miss in IDLE: if BG_input=0, go to REQ. If BG_input=1, go to WAIT_BG.
- WAIT_BG: move to REQ on the first cycle BG_input=0. If read_m drops, return to IDLE.
- REQ: mem_read_m=1. out_address is latched at REQ entry. At the edge where mem_ready=1, install the line into the victim way: valid=1, tag written, LRU updated. Then return to IDLE. BG_input rising during REQ has no effect; the bus is already ours.
- Victim selection: lowest-index invalid way; otherwise the oldest way.
- LRU: per-set age per way, log2(WAYS) bits. On access or fill, the accessed way's age becomes 0 and ways younger than its old age increment by 1. Reset ages: way i = i.
- invalidate: at the next edge, clear all valid bits in any state. In REQ the request still completes (the response must be consumed), but the line is not installed. This holds also when invalidate coincides with the mem_ready edge.
- Counters, all wrapping modulo 2^CNT_W:
  - hit_count +1 per hit cycle.
  - miss_count +1 per line install.
  - evict_count +1 per install over a valid line.

## Timing
- Reset values: state IDLE, all valid=0, ages = way index, counters 0, mem_read_m=0, out_address=0.
- Outputs with read_m=0: hit=0, miss=0, data=0.
- Hit latency: 0 cycles (same-cycle data).
- Miss penalty with BG_input=0 and memory latency L cycles from mem_read_m to mem_ready:
  - cycle 0: miss detected.
  - cycles 1..L: REQ.
  - L+1: IDLE, hit.
- mem_read_m is low the cycle after the mem_ready edge.
- reset mid-REQ: IDLE next cycle, mem_read_m=0, any late mem_ready ignored.
- miss stays 1 through WAIT_BG and REQ. hit is never asserted outside IDLE.
- WAYS=1: direct-mapped, no LRU state.

## Test plan
- Defaults, cold fetch 0x0012, L=3, instruction=0x4444_3333_2222_1111:
  - mem_read_m high for cycles 1..3, out_address=0x0010.
  - cycle 4: hit=1, data=0x3333 (offset 2).
  - miss_count=1, evict_count=0.
- Fetches 0x0000, 0x0008, 0x0000, 0x0010 (same set 0):
  - third fetch hits.
  - fourth evicts the 0x0008 line (LRU): evict_count=1.
  - refetching 0x0000 hits; refetching 0x0008 misses.
- BG_input=1 at miss on 0x0020:
  - mem_read_m stays 0 for 5 cycles.
  - BG_input drops: mem_read_m=1 the next cycle.
- invalidate pulsed on the same edge as mem_ready for 0x0030:
  - state returns to IDLE, line not valid.
  - refetch misses again, miss_count unchanged by the discarded fill.
- reset asserted during REQ:
  - next cycle mem_read_m=0, counters 0.
  - prior lines miss.
- WAYS=4, SETS=1: fetch 5 distinct lines, then refetch the first → miss. 4 hits on lines 2–5 counted: hit_count=4.
